// File: rtl/icache_responder_if.sv
// -----------------------------------------------------------------------------
// icache_responder_if
//
// Bundles the fetch-side request/response signals and the memory-arbiter
// refill signals of the instruction cache responder.
//
// Handshake rules:
//   fetch side : next_inst is a level request for the halfword-aligned
//                address next_PC. The cache answers with a one-cycle
//                inst_rdy strobe and the 32 bits at next_PC..next_PC+3 on
//                inst_in. flush discards any request that has not yet been
//                answered.
//   refill side: mem_req rises with mem_addr holding the line base and stays
//                high until the last byte of the line is accepted. Each cycle
//                with mem_vld=1 delivers one byte, in ascending address
//                order. There is no back-pressure toward the arbiter.
//
// Modports:
//   slave  : the cache (drives inst_rdy, inst_in, mem_req, mem_addr)
//   master : the environment (fetch unit + arbiter)
// -----------------------------------------------------------------------------
interface icache_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] next_PC;
  logic                  next_inst;
  logic                  flush;
  logic                  inst_rdy;
  logic [INST_WIDTH-1:0] inst_in;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_vld;
  logic [7:0]            mem_byte;

  modport slave (
    input  next_PC, next_inst, flush, mem_vld, mem_byte,
    output inst_rdy, inst_in, mem_req, mem_addr
  );

  modport master (
    output next_PC, next_inst, flush, mem_vld, mem_byte,
    input  inst_rdy, inst_in, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_responder.sv
// -----------------------------------------------------------------------------
// icache_responder
//
// Direct-mapped, byte-refilled instruction cache sitting between the fetch
// unit and the memory arbiter. Any halfword-aligned PC returns 32 bits, so
// both compressed (16-bit) and full (32-bit) instructions are served,
// including a 32-bit instruction that straddles two lines.
//
// Ports:
//   clk        clock
//   rst_in     asynchronous active-low reset
//   rdy_in     global enable; low freezes every register
//   bus        icache_responder_if.slave (fetch request/response + refill)
//   state_o    current FSM state (0 IDLE, 1 REFILL, 2 RESP) for observation
//   perf_hit   (ICACHE_PERF_EN only) count of IDLE->RESP transitions
//   perf_miss  (ICACHE_PERF_EN only) count of IDLE->REFILL transitions
//
// Optional feature: define ICACHE_PERF_EN to add the two 32-bit wrapping
// performance counters. Without it the counters and ports do not exist.
// -----------------------------------------------------------------------------
module icache_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int LINE_BYTES = 16,
  parameter int LINES      = 64
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic              rdy_in,
  icache_responder_if.slave bus,
  output logic [1:0]        state_o
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]       perf_hit,
  output logic [31:0]       perf_miss
`endif
);

  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_WIDTH - OFF_W - IDX_W;
  localparam int DA_W  = IDX_W + OFF_W;

  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(LINE_BYTES - 1);
  localparam logic [OFF_W-1:0] OFF_END  = OFF_W'(LINE_BYTES - 2);
  localparam logic [OFF_W-1:0] OFF_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    RESP   = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Storage. Data and tags need no reset: a line is only read once its valid
  // bit is set, and valid bits are cleared by reset.
  // ---------------------------------------------------------------------------
  logic [7:0]       data_q [LINES*LINE_BYTES];
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [LINES-1:0] valid_q;

  state_e                state_q;
  logic [OFF_W-1:0]      cnt_q;
  logic                  mem_req_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  inst_rdy_q;
  logic [INST_WIDTH-1:0] inst_in_q;

`ifdef ICACHE_PERF_EN
  logic [31:0] perf_hit_q;
  logic [31:0] perf_miss_q;
`endif

  // ---------------------------------------------------------------------------
  // Combinational lookup on next_PC. Line A holds PC, line B is the next
  // sequential line; B's tag is bumped when A sits in the last index so that
  // the address keeps increasing across the index wrap.
  // ---------------------------------------------------------------------------
  logic [OFF_W-1:0]      pc_off;
  logic [IDX_W-1:0]      idx_a;
  logic [IDX_W-1:0]      idx_b;
  logic [TAG_W-1:0]      tag_a;
  logic [TAG_W-1:0]      tag_b;
  logic                  at_end;
  logic                  hit_a;
  logic                  hit_b;
  logic                  need_b;
  logic                  lookup_hit;
  logic [DA_W-1:0]       addr0;
  logic [DA_W-1:0]       addr1;
  logic [DA_W-1:0]       addr2;
  logic [DA_W-1:0]       addr3;
  logic [7:0]            byte0;
  logic [7:0]            byte1;
  logic [7:0]            byte2;
  logic [7:0]            byte3;
  logic [31:0]           word_d;
  logic [ADDR_WIDTH-1:0] miss_addr_d;

  always_comb begin
    pc_off = bus.next_PC[OFF_W-1:0];
    idx_a  = bus.next_PC[OFF_W +: IDX_W];
    tag_a  = bus.next_PC[ADDR_WIDTH-1 -: TAG_W];
    idx_b  = idx_a + IDX_W'(1);
    tag_b  = (idx_a == {IDX_W{1'b1}}) ? tag_a + TAG_W'(1) : tag_a;
    at_end = (pc_off == OFF_END);

    // The first halfword always lives in line A; the second halfword moves
    // to the start of line B when PC is in the last halfword of A.
    addr0 = {idx_a, pc_off};
    addr1 = {idx_a, pc_off + OFF_W'(1)};
    if (at_end) begin
      addr2 = {idx_b, OFF_ZERO};
      addr3 = {idx_b, OFF_W'(1)};
    end else begin
      addr2 = {idx_a, pc_off + OFF_W'(2)};
      addr3 = {idx_a, pc_off + OFF_W'(3)};
    end

    byte0 = data_q[addr0];
    byte1 = data_q[addr1];
    byte2 = data_q[addr2];
    byte3 = data_q[addr3];

    hit_a = valid_q[idx_a] && (tag_q[idx_a] == tag_a);
    hit_b = valid_q[idx_b] && (tag_q[idx_b] == tag_b);

    // Only a 32-bit instruction (low bits 11) in the last halfword needs B.
    need_b     = at_end && (byte0[1:0] == 2'b11);
    lookup_hit = hit_a && (!need_b || hit_b);

    // A compressed instruction at the line end may be served while B is
    // absent; its unused upper half is then returned as zero.
    word_d = {byte3, byte2, byte1, byte0};
    if (at_end && !hit_b) begin
      word_d[31:16] = 16'h0000;
    end

    // Line A is always refilled before line B.
    if (hit_a) begin
      miss_addr_d = {tag_b, idx_b, OFF_ZERO};
    end else begin
      miss_addr_d = {tag_a, idx_a, OFF_ZERO};
    end
  end

  // ---------------------------------------------------------------------------
  // Refill write path. Bytes land at offset cnt_q of the line named by
  // mem_addr_q; the tag is written together with the final byte.
  // ---------------------------------------------------------------------------
  logic             fill_we;
  logic             fill_last;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;

  assign fill_we   = rdy_in && (state_q == REFILL) && bus.mem_vld;
  assign fill_last = fill_we && (cnt_q == OFF_LAST);
  assign fill_idx  = mem_addr_q[OFF_W +: IDX_W];
  assign fill_tag  = mem_addr_q[ADDR_WIDTH-1 -: TAG_W];

  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_q[{fill_idx, cnt_q}] <= bus.mem_byte;
    end
    if (fill_last) begin
      tag_q[fill_idx] <= fill_tag;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs.
  //   IDLE   : sample the request (unless flushed) and resolve hit/miss.
  //   REFILL : collect LINE_BYTES bytes; flush cannot abort the arbiter, so
  //            the line is always installed. Return to IDLE, which looks up
  //            whatever next_PC holds by then.
  //   RESP   : single strobe cycle; the fetcher moves next_PC on the edge
  //            leaving RESP, so nothing is sampled here.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      inst_rdy_q  <= 1'b0;
      inst_in_q   <= '0;
`ifdef ICACHE_PERF_EN
      perf_hit_q  <= '0;
      perf_miss_q <= '0;
`endif
    end else if (rdy_in) begin
      case (state_q)
        IDLE: begin
          if (bus.next_inst && !bus.flush) begin
            if (lookup_hit) begin
              inst_in_q  <= INST_WIDTH'(word_d);
              inst_rdy_q <= 1'b1;
              state_q    <= RESP;
`ifdef ICACHE_PERF_EN
              perf_hit_q <= perf_hit_q + 32'd1;
`endif
            end else begin
              mem_addr_q  <= miss_addr_d;
              mem_req_q   <= 1'b1;
              cnt_q       <= '0;
              state_q     <= REFILL;
`ifdef ICACHE_PERF_EN
              perf_miss_q <= perf_miss_q + 32'd1;
`endif
            end
          end
        end

        REFILL: begin
          if (bus.mem_vld) begin
            if (cnt_q == OFF_LAST) begin
              valid_q[fill_idx] <= 1'b1;
              mem_req_q         <= 1'b0;
              cnt_q             <= '0;
              state_q           <= IDLE;
            end else begin
              cnt_q <= cnt_q + OFF_W'(1);
            end
          end
        end

        RESP: begin
          inst_rdy_q <= 1'b0;
          state_q    <= IDLE;
        end

        default: begin
          inst_rdy_q <= 1'b0;
          mem_req_q  <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  // A flush arriving in the RESP cycle kills the strobe of that cycle.
  assign bus.inst_rdy = inst_rdy_q && !bus.flush;
  assign bus.inst_in  = inst_in_q;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;
  assign state_o      = state_q;

`ifdef ICACHE_PERF_EN
  assign perf_hit  = perf_hit_q;
  assign perf_miss = perf_miss_q;
`endif

endmodule

// File: tb/tb_icache_responder.sv
// -----------------------------------------------------------------------------
// tb_icache_responder
//
// Drives fetch requests and plays the memory arbiter. Expected refill
// addresses and instruction words come from a line-level model of the cache
// (which line numbers are resident) and a flat byte image of memory.
// -----------------------------------------------------------------------------
module tb_icache_responder;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst_in;
  logic       rdy_in;
  logic [1:0] state_o;
`ifdef ICACHE_PERF_EN
  logic [31:0] perf_hit;
  logic [31:0] perf_miss;
`endif

  always #5 clk = ~clk;

  icache_responder_if bus_if ();

  icache_responder dut (
    .clk      (clk),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .bus      (bus_if),
    .state_o  (state_o)
`ifdef ICACHE_PERF_EN
    ,
    .perf_hit (perf_hit),
    .perf_miss(perf_miss)
`endif
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model
  // ---------------------------------------------------------------------------
  int          total = 0;
  int          bad   = 0;
  logic [7:0]  mem_img [4096];
  bit          mvalid  [64];
  int          mline   [64];
  logic [31:0] exp_q [$];
  bit          dense;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    return mem_img[a[11:0]];
  endfunction

  function automatic bit present(input int line);
    return mvalid[line % 64] && (mline[line % 64] == line);
  endfunction

  function automatic bit needs_b(input logic [31:0] pc);
    logic [7:0] b;
    b = mem_rd(pc);
    return (pc[3:0] == 4'hE) && (b[1:0] == 2'b11);
  endfunction

  // Line number of the first line the fetch still lacks, or -1.
  function automatic int first_missing(input logic [31:0] pc);
    int la;
    la = int'(pc >> 4);
    if (!present(la)) return la;
    if (needs_b(pc) && !present(la + 1)) return la + 1;
    return -1;
  endfunction

  function automatic void install(input int line);
    mvalid[line % 64] = 1'b1;
    mline[line % 64]  = line;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 64; i++) begin
      mvalid[i] = 1'b0;
      mline[i]  = 0;
    end
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] pc);
    logic [7:0] b0, b1, b2, b3;
    b0 = mem_rd(pc);
    b1 = mem_rd(pc + 32'd1);
    b2 = mem_rd(pc + 32'd2);
    b3 = mem_rd(pc + 32'd3);
    if (pc[3:0] == 4'hE && !present(int'(pc >> 4) + 1)) begin
      b2 = 8'h00;
      b3 = 8'h00;
    end
    return {b3, b2, b1, b0};
  endfunction

  // Queue every refill a fetch of pc will cause, updating the model.
  task automatic plan(input logic [31:0] pc);
    int m;
    m = first_missing(pc);
    while (m >= 0) begin
      exp_q.push_back(32'(m) << 4);
      install(m);
      m = first_missing(pc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic apply_reset();
    rst_in           = 1'b0;
    rdy_in           = 1'b1;
    bus_if.next_PC   = '0;
    bus_if.next_inst = 1'b0;
    bus_if.flush     = 1'b0;
    bus_if.mem_vld   = 1'b0;
    bus_if.mem_byte  = '0;
    repeat (3) @(negedge clk);
    rst_in = 1'b1;
    model_clear();
  endtask

  // One fetch of pc. flush_at >= 0 pulses flush (and moves next_PC to pc2)
  // while refill byte number flush_at is delivered; rst_at >= 0 drops the
  // asynchronous reset once that many refill bytes have been delivered.
  task automatic run_fetch(input logic [31:0] pc, input int flush_at,
                           input logic [31:0] pc2, input int rst_at);
    int n, cnt, seen, exp_total, fa, ra, m;
    bit logged, got, flushed, aborted;
    logic [31:0] data, exp_data, srv_pc;

    fa = flush_at;
    ra = rst_at;
    exp_q.delete();
    m = first_missing(pc);
    if (m < 0) begin
      fa = -1;
      ra = -1;
    end
    if (ra >= 0) begin
      exp_q.push_back(32'(m) << 4);
    end else if (fa >= 0) begin
      exp_q.push_back(32'(m) << 4);
      install(m);
      plan(pc2);
    end else begin
      plan(pc);
    end
    srv_pc    = (fa >= 0) ? pc2 : pc;
    exp_data  = exp_word(srv_pc);
    exp_total = exp_q.size();

    bus_if.next_PC   = pc;
    bus_if.next_inst = 1'b1;
    bus_if.flush     = 1'b0;
    n = 0; cnt = 0; seen = 0;
    logged = 0; got = 0; flushed = 0; aborted = 0;
    data = '0;

    while (!got && n < 400) begin
      @(negedge clk);
      n++;
      bus_if.flush    = 1'b0;
      bus_if.mem_vld  = 1'b0;
      bus_if.mem_byte = 8'($urandom);
      rdy_in          = 1'b1;
      if (bus_if.inst_rdy) begin
        got  = 1;
        data = bus_if.inst_in;
        check("mem_req_at_resp", 32'(bus_if.mem_req), 32'd0);
      end else if (bus_if.mem_req) begin
        if (!logged) begin
          logged = 1;
          seen++;
          if (exp_q.size() > 0) check("refill_addr", bus_if.mem_addr, exp_q.pop_front());
        end
        if (ra >= 0 && cnt == ra) begin
          #2 rst_in = 1'b0;
          #1;
          check("rst_mem_req", 32'(bus_if.mem_req), 32'd0);
          check("rst_inst_rdy", 32'(bus_if.inst_rdy), 32'd0);
          check("rst_mem_addr", bus_if.mem_addr, 32'd0);
          check("rst_state", 32'(state_o), 32'd0);
          model_clear();
          bus_if.next_inst = 1'b0;
          repeat (2) @(negedge clk);
          rst_in  = 1'b1;
          aborted = 1;
          break;
        end
        if (!dense && $urandom_range(0, 7) == 0) begin
          // Frozen cycle: the byte offered here must not be consumed.
          rdy_in         = 1'b0;
          bus_if.mem_vld = 1'b1;
        end else if (cnt < 16 && (dense || $urandom_range(0, 3) != 0)) begin
          bus_if.mem_vld  = 1'b1;
          bus_if.mem_byte = mem_rd(bus_if.mem_addr + 32'(cnt));
          if (fa >= 0 && !flushed && cnt == fa) begin
            bus_if.flush   = 1'b1;
            bus_if.next_PC = pc2;
            flushed        = 1;
          end
          cnt++;
        end
      end else begin
        // No refill in progress: stray strobes must be ignored.
        logged         = 0;
        cnt            = 0;
        bus_if.mem_vld = 1'($urandom_range(0, 1));
      end
    end

    check("refills", 32'(seen), 32'(exp_total));
    if (!aborted) begin
      check("resp_seen", 32'(got), 32'd1);
      check("inst_in", data, exp_data);
      if (dense && fa < 0) check("latency", 32'(n), 32'(17 * exp_total + 1));
      bus_if.next_inst = 1'b0;
      bus_if.mem_vld   = 1'b0;
      rdy_in           = 1'b1;
      @(negedge clk);
      check("rdy_pulse", 32'(bus_if.inst_rdy), 32'd0);
      check("back_idle", 32'(state_o), 32'd0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] pc, pc2;
    int fa;

    for (int i = 0; i < 4096; i++) mem_img[i] = 8'($urandom);
    for (int i = 0; i < 64; i++) mem_img[i] = 8'(i);
    mem_img[12'h00E] = 8'h13;
    mem_img[12'h01E] = 8'h01;
    mem_img[12'h3FE] = 8'h03;

    dense = 1;
    apply_reset();
    check("reset_inst_rdy", 32'(bus_if.inst_rdy), 32'd0);
    check("reset_inst_in", bus_if.inst_in, 32'd0);
    check("reset_mem_req", 32'(bus_if.mem_req), 32'd0);
    check("reset_mem_addr", bus_if.mem_addr, 32'd0);
    check("reset_state", 32'(state_o), 32'd0);

    // Cold miss, then hit in the same line.
    run_fetch(32'h0, -1, 32'h0, -1);
    check("cold_word", bus_if.inst_in, 32'h03020100);
    run_fetch(32'h4, -1, 32'h0, -1);
    check("hit_word", bus_if.inst_in, 32'h07060504);

    // 32-bit straddle refills line 0x10; compressed straddle does not.
    run_fetch(32'hE, -1, 32'h0, -1);
    check("straddle32_word", bus_if.inst_in, 32'h11100F13);
    run_fetch(32'h1E, -1, 32'h0, -1);
    check("straddle16_word", bus_if.inst_in, 32'h00001F01);

    // Flush in IDLE: request ignored.
    bus_if.next_PC   = 32'h4;
    bus_if.next_inst = 1'b1;
    bus_if.flush     = 1'b1;
    @(negedge clk);
    check("flush_idle_rdy", 32'(bus_if.inst_rdy), 32'd0);
    check("flush_idle_state", 32'(state_o), 32'd0);
    bus_if.flush = 1'b0;

    // Flush in RESP: strobe suppressed.
    @(negedge clk);
    check("resp_state", 32'(state_o), 32'd2);
    bus_if.flush = 1'b1;
    #1;
    check("flush_resp_rdy", 32'(bus_if.inst_rdy), 32'd0);
    bus_if.next_inst = 1'b0;
    @(negedge clk);
    bus_if.flush = 1'b0;
    check("flush_resp_after", 32'(bus_if.inst_rdy), 32'd0);
    check("flush_resp_idle", 32'(state_o), 32'd0);

    // Index wrap: line 0x3F0 then 0x400 (index 0, next tag).
    run_fetch(32'h3FE, -1, 32'h0, -1);

    // Flush during refill, then the flushed line hits.
    run_fetch(32'h100, 5, 32'h0, -1);
    check("post_flush_word", bus_if.inst_in, 32'h03020100);
    run_fetch(32'h100, -1, 32'h0, -1);

    // Flush together with the final refill byte.
    run_fetch(32'h300, 15, 32'h4, -1);

    // Asynchronous reset mid-refill; line 0 must miss afterwards.
    run_fetch(32'h200, -1, 32'h0, 3);
    run_fetch(32'h0, -1, 32'h0, -1);

    // Randomized traffic over a 2 KB window (twice the cache size).
    for (int it = 0; it < 200; it++) begin
      dense = 1'($urandom_range(0, 1));
      pc = 32'($urandom_range(0, 127)) << 4;
      if ($urandom_range(0, 3) == 0) pc = pc | 32'hE;
      else pc = pc | (32'($urandom_range(0, 7)) << 1);
      pc2 = (32'($urandom_range(0, 127)) << 4) | (32'($urandom_range(0, 7)) << 1);
      fa  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : -1;
      run_fetch(pc, fa, pc2, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
